// File: rtl/pwm_fade_ctrl.sv
// Duty-word sequencer for a pwm instance: ramps w one LSB per step toward a loaded
// target at a programmable PWM-period cadence, or snaps it there in one cycle.
module pwm_fade_ctrl #(
  parameter int unsigned N      = 4,
  parameter int unsigned RATE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      target,
  input  logic [RATE_W-1:0] rate,
  input  logic              load,
  input  logic              snap,
  output logic [N-1:0]      w,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        per_cnt_q, per_cnt_d;
  logic [RATE_W-1:0]   step_cnt_q, step_cnt_d;
  logic [N-1:0]        tgt_q, tgt_d;
  logic [RATE_W-1:0]   rate_q, rate_d;
  logic [N-1:0]        w_q, w_d;
  logic                done_q, done_d;

  logic                per_end;
  logic [N-1:0]        w_step;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      per_cnt_q  <= '0;
      step_cnt_q <= '0;
      tgt_q      <= '0;
      rate_q     <= '0;
      w_q        <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      step_cnt_q <= step_cnt_d;
      tgt_q      <= tgt_d;
      rate_q     <= rate_d;
      w_q        <= w_d;
      done_q     <= done_d;
    end
  end

  assign per_end = (per_cnt_q == '1);
  assign w_step  = (state_q == UP) ? (w_q + 1'b1) : (w_q - 1'b1);

  // Next-state logic; strobes take priority over a step falling on the same edge
  always_comb begin
    state_d    = state_q;
    per_cnt_d  = per_cnt_q + 1'b1;
    step_cnt_d = step_cnt_q;
    tgt_d      = tgt_q;
    rate_d     = rate_q;
    w_d        = w_q;
    done_d     = 1'b0;

    if (snap) begin
      tgt_d      = target;
      w_d        = target;
      state_d    = IDLE;
      step_cnt_d = '0;
      done_d     = 1'b1;
    end else if (load) begin
      tgt_d  = target;
      rate_d = rate;
      // A retarget mid-ramp keeps the step cadence running
      if (state_q == IDLE) begin
        step_cnt_d = '0;
      end
      if (target > w_q) begin
        state_d = UP;
      end else if (target < w_q) begin
        state_d = DOWN;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if ((state_q != IDLE) && per_end) begin
      if (step_cnt_q == rate_q) begin
        step_cnt_d = '0;
        w_d        = w_step;
        if (w_step == tgt_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else begin
        step_cnt_d = step_cnt_q + 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    busy = (state_q != IDLE);
    w    = w_q;
    done = done_q;
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: stimulus queues expected w/done events with their
// cycle numbers; a negedge monitor pops one whenever w changes or done pulses.
module tb_pwm_fade_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] target = '0;
  logic [3:0] rate   = '0;
  logic       load   = 1'b0;
  logic       snap   = 1'b0;
  logic [3:0] w;
  logic       busy;
  logic       done;

  typedef struct {
    int         cyc;
    logic [3:0] w;
    logic       busy;
    logic       done;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;
  int  cyc    = 0;
  logic [3:0] prev_w = '0;

  pwm_fade_ctrl #(.N(4), .RATE_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .target (target),
    .rate   (rate),
    .load   (load),
    .snap   (snap),
    .w      (w),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // cyc == per_cnt (mod 16) of the DUT
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (w !== prev_w || done !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL stray_event cyc=%0d w=%0d busy=%0d done=%0d, none expected",
                 cyc, w, busy, done);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (cyc == e.cyc && w === e.w && busy === e.busy && done === e.done) begin
          passes++;
        end else begin
          $display("FAIL event got cyc=%0d w=%0d busy=%0d done=%0d, expected cyc=%0d w=%0d busy=%0d done=%0d",
                   cyc, w, busy, done, e.cyc, e.w, e.busy, e.done);
        end
      end
    end
    prev_w = w;
  end

  task automatic expect_ev(input int c, input logic [3:0] ew, input logic eb, input logic ed);
    ev_t e;
    e.cyc = c; e.w = ew; e.busy = eb; e.done = ed;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s got %0d expected %0d (cyc=%0d)", name, act, exp, cyc);
  endtask

  task automatic goto(input int c);
    if (cyc > c) begin
      checks++;
      $display("FAIL schedule got cyc=%0d expected at most %0d", cyc, c);
    end
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input int c, input logic ld, input logic sn,
                        input logic [3:0] tgt, input logic [3:0] rt);
    goto(c);
    load = ld; snap = sn; target = tgt; rate = rt;
    @(posedge clk);
    #1;
    load = 1'b0; snap = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got cyc=%0d expected bench to finish", cyc);
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("reset_w", {4'd0, w}, 8'd0);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_done", {7'd0, done}, 8'd0);
    #1 reset = 1'b1;

    // Ramp 0->3 at rate 0
    expect_ev(16, 4'd1, 1'b1, 1'b0);
    expect_ev(32, 4'd2, 1'b1, 1'b0);
    expect_ev(48, 4'd3, 1'b0, 1'b1);
    goto(2);
    chk("t1_busy_before", {7'd0, busy}, 8'd0);
    strobe(2, 1'b1, 1'b0, 4'd3, 4'd0);
    chk("t1_busy_after_load", {7'd0, busy}, 8'd1);
    chk("t1_w_after_load", {4'd0, w}, 8'd0);
    goto(50);
    chk("t1_busy_end", {7'd0, busy}, 8'd0);
    chk("t1_w_end", {4'd0, w}, 8'd3);

    // snap wins over load in the same cycle
    expect_ev(53, 4'd12, 1'b0, 1'b1);
    strobe(52, 1'b1, 1'b1, 4'd12, 4'd5);
    chk("t5_busy", {7'd0, busy}, 8'd0);

    // Load of the current value: done next cycle, stays idle
    expect_ev(57, 4'd7, 1'b0, 1'b1);
    strobe(56, 1'b0, 1'b1, 4'd7, 4'd0);
    expect_ev(61, 4'd7, 1'b0, 1'b1);
    strobe(60, 1'b1, 1'b0, 4'd7, 4'd0);

    // Ramp 0->2 at rate 2: one step every third per_end (79,95,111 / 127,143,159)
    expect_ev(63, 4'd0, 1'b0, 1'b1);
    strobe(62, 1'b0, 1'b1, 4'd0, 4'd0);
    expect_ev(112, 4'd1, 1'b1, 1'b0);
    expect_ev(160, 4'd2, 1'b0, 1'b1);
    strobe(64, 1'b1, 1'b0, 4'd2, 4'd2);
    chk("t2_busy", {7'd0, busy}, 8'd1);
    goto(100);
    chk("t2_w_mid", {4'd0, w}, 8'd0);

    // Ramp toward 10, reverse to 2 at w=5
    expect_ev(163, 4'd0, 1'b0, 1'b1);
    strobe(162, 1'b0, 1'b1, 4'd0, 4'd0);
    for (int i = 1; i <= 5; i++) expect_ev(160 + 16 * i, i[3:0], 1'b1, 1'b0);
    strobe(164, 1'b1, 1'b0, 4'd10, 4'd0);
    expect_ev(256, 4'd4, 1'b1, 1'b0);
    expect_ev(272, 4'd3, 1'b1, 1'b0);
    expect_ev(288, 4'd2, 1'b0, 1'b1);
    strobe(242, 1'b1, 1'b0, 4'd2, 4'd0);
    chk("t3_busy_down", {7'd0, busy}, 8'd1);

    // Upper and lower limits as targets
    expect_ev(291, 4'd14, 1'b0, 1'b1);
    strobe(290, 1'b0, 1'b1, 4'd14, 4'd0);
    expect_ev(304, 4'd15, 1'b0, 1'b1);
    strobe(292, 1'b1, 1'b0, 4'd15, 4'd0);
    expect_ev(307, 4'd1, 1'b0, 1'b1);
    strobe(306, 1'b0, 1'b1, 4'd1, 4'd0);
    expect_ev(320, 4'd0, 1'b0, 1'b1);
    strobe(308, 1'b1, 1'b0, 4'd0, 4'd0);

    // Async reset mid-ramp at w=6
    for (int i = 1; i <= 6; i++) expect_ev(320 + 16 * i, i[3:0], 1'b1, 1'b0);
    strobe(322, 1'b1, 1'b0, 4'd10, 4'd0);
    goto(420);
    chk("t6_w_before_reset", {4'd0, w}, 8'd6);
    expect_ev(0, 4'd0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("t6_w_in_reset", {4'd0, w}, 8'd0);
    chk("t6_busy_in_reset", {7'd0, busy}, 8'd0);
    chk("t6_done_in_reset", {7'd0, done}, 8'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    goto(40);
    chk("t6_w_hold", {4'd0, w}, 8'd0);
    chk("t6_busy_hold", {7'd0, busy}, 8'd0);

    chk("events_left", exp_q.size() > 255 ? 8'd255 : 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
